// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - issue stage for the 8-bit ALU: op FIFO, operand registers, result capture
module alu_op_issue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_ctl,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic        in_use_acc,
    output logic [3:0]  ALU_CTL,
    output logic [7:0]  A,
    output logic [7:0]  B,
    input  logic [7:0]  Z,
    input  logic [7:0]  FLAGS,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_z,
    output logic [7:0]  out_flags,
    output logic [7:0]  acc,
    output logic [15:0] ops_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t        state;
    logic [20:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          not_empty;

    // Entry layout: {ctl[20:17], a[16:9], b[8:1], use_acc[0]}
    logic [20:0]   head;
    logic [3:0]    head_ctl;
    logic [7:0]    head_a;
    logic [7:0]    head_b;
    logic          head_use_acc;

    assign head         = mem[rd_ptr];
    assign head_ctl     = head[20:17];
    assign head_a       = head[16:9];
    assign head_b       = head[8:1];
    assign head_use_acc = head[0];

    assign not_empty = (count != '0);
    assign in_ready  = (count != CW'(DEPTH));
    assign push      = in_valid && in_ready;

    always_comb begin
        pop = 1'b0;
        if (state == IDLE && not_empty) begin
            pop = 1'b1;
        end else if (state == WAIT && out_ready && not_empty) begin
            pop = 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_ctl, in_a, in_b, in_use_acc};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            ALU_CTL   <= '0;
            A         <= '0;
            B         <= '0;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_flags <= '0;
            acc       <= '0;
            ops_done  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // acc here already reflects the previous retire, so chained ops see it directly.
            if (pop) begin
                ALU_CTL <= head_ctl;
                A       <= head_use_acc ? acc : head_a;
                B       <= head_b;
            end

            case (state)
                IDLE: begin
                    if (not_empty) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    out_z     <= Z;
                    out_flags <= FLAGS;
                    acc       <= Z;
                    out_valid <= 1'b1;
                    ops_done  <= ops_done + 16'd1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= not_empty ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - directed bench for alu_op_issue with an adder ALU stub
module tb_alu_op_issue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctl;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_use_acc;
    logic [3:0]  ALU_CTL;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [7:0]  Z;
    logic [7:0]  FLAGS;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_z;
    logic [7:0]  out_flags;
    logic [7:0]  acc;
    logic [15:0] ops_done;

    int vectors    = 0;
    int miscompares = 0;
    int last_wait  = 0;

    logic [8:0] sum;
    assign sum   = {1'b0, A} + {1'b0, B};
    assign Z     = sum[7:0];
    assign FLAGS = {7'b0, sum[8]};

    always #5 clk = ~clk;

    alu_op_issue #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctl     (in_ctl),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_use_acc (in_use_acc),
        .ALU_CTL    (ALU_CTL),
        .A          (A),
        .B          (B),
        .Z          (Z),
        .FLAGS      (FLAGS),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_flags  (out_flags),
        .acc        (acc),
        .ops_done   (ops_done)
    );

    // Fill vectors: 01+02, 80+80, FF+01, 7F+7F, 55+AA
    logic [7:0] fa [5] = '{8'h01, 8'h80, 8'hFF, 8'h7F, 8'h55};
    logic [7:0] fb [5] = '{8'h02, 8'h80, 8'h01, 8'h7F, 8'hAA};
    logic [7:0] fz [5] = '{8'h03, 8'h00, 8'h00, 8'hFE, 8'hFF};
    logic [7:0] ff [5] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_op(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                           input logic ua);
        in_valid   = 1'b1;
        in_ctl     = c;
        in_a       = a;
        in_b       = b;
        in_use_acc = ua;
        tick();
        in_valid   = 1'b0;
    endtask

    // Waits for out_valid, checks the result, then lets the handshake edge pass (out_ready=1).
    task automatic wait_result(input string tag, input logic [7:0] ez, input logic [7:0] ef);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, " valid"}, 16'(out_valid), 16'd1);
        check({tag, " z"}, 16'(out_z), 16'(ez));
        check({tag, " flags"}, 16'(out_flags), 16'(ef));
        last_wait = n;
        tick();
    endtask

    initial begin
        logic [15:0] gq [$];
        logic [15:0] obs;
        logic [15:0] exp_r;
        logic [8:0]  s;
        logic        push_fire;
        logic        pop_fire;
        int          sent;
        int          got;
        int          cyc;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_ctl     = 4'h0;
        in_a       = 8'h00;
        in_b       = 8'h00;
        in_use_acc = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("reset in_ready", 16'(in_ready), 16'd1);
        check("reset out_valid", 16'(out_valid), 16'd0);
        check("reset acc", 16'(acc), 16'd0);
        check("reset ops_done", ops_done, 16'd0);
        check("reset A/B/ctl", {4'(0), ALU_CTL, A}, 16'd0);
        check("reset out_z", {out_flags, out_z}, 16'd0);

        // Single op
        push_op(4'h0, 8'h12, 8'h34, 1'b0);
        tick();
        check("t1 issue A", 16'(A), 16'h12);
        check("t1 issue B", 16'(B), 16'h34);
        check("t1 not yet valid", 16'(out_valid), 16'd0);
        tick();
        check("t1 valid", 16'(out_valid), 16'd1);
        check("t1 z", 16'(out_z), 16'h46);
        check("t1 flags", 16'(out_flags), 16'h00);
        check("t1 acc", 16'(acc), 16'h46);
        check("t1 ops_done", ops_done, 16'd1);
        tick();
        check("t1 valid drop", 16'(out_valid), 16'd0);
        tick();

        // Carry then chain through the accumulator
        push_op(4'h0, 8'hF0, 8'h20, 1'b0);
        push_op(4'hA, 8'h77, 8'h01, 1'b1);
        tick();
        check("t2 first z", 16'(out_z), 16'h10);
        check("t2 first flags", 16'(out_flags), 16'h01);
        tick();
        check("t2 chain A", 16'(A), 16'h10);
        check("t2 chain ctl", 16'(ALU_CTL), 16'hA);
        tick();
        check("t2 second z", 16'(out_z), 16'h11);
        check("t2 second flags", 16'(out_flags), 16'h00);
        check("t2 ops_done", ops_done, 16'd3);
        tick();
        tick();

        // Fill with the consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("t3 ready before 5th", 16'(in_ready), 16'd1);
            push_op(4'h0, fa[i], fb[i], 1'b0);
        end
        check("t3 full in_ready", 16'(in_ready), 16'd0);
        check("t3 first valid", 16'(out_valid), 16'd1);
        check("t3 first z", 16'(out_z), 16'h03);
        check("t3 ops_done", ops_done, 16'd4);

        // Backpressure: stable outputs, an attempted push while full is dropped
        in_valid = 1'b1;
        in_a     = 8'hAA;
        in_b     = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            tick();
            in_valid = 1'b0;
            check("t4 stable z", {out_flags, out_z}, 16'h0003);
            check("t4 stable valid", 16'(out_valid), 16'd1);
        end
        check("t4 ops_done held", ops_done, 16'd4);
        check("t4 in_ready", 16'(in_ready), 16'd0);

        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_result($sformatf("t3 result %0d", i), fz[i], ff[i]);
            if (i > 0) check("t3 gap", 16'(last_wait), 16'd1);
        end
        tick();
        tick();
        check("t3 drained valid", 16'(out_valid), 16'd0);
        check("t3 drained ops_done", ops_done, 16'd9 - 16'd1);

        // Reset while in EXEC with three queued
        out_ready = 1'b0;
        push_op(4'h0, 8'h01, 8'h01, 1'b0);
        push_op(4'h0, 8'h02, 8'h02, 1'b0);
        push_op(4'h0, 8'h03, 8'h03, 1'b0);
        push_op(4'h0, 8'h04, 8'h04, 1'b0);
        out_ready = 1'b1;
        push_op(4'h0, 8'h05, 8'h05, 1'b0);
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5 out_valid", 16'(out_valid), 16'd0);
        check("t5 acc", 16'(acc), 16'd0);
        check("t5 ops_done", ops_done, 16'd0);
        check("t5 in_ready", 16'(in_ready), 16'd1);
        tick();
        tick();
        tick();
        check("t5 stays idle", 16'(out_valid), 16'd0);
        out_ready = 1'b1;
        push_op(4'h0, 8'h12, 8'h34, 1'b0);
        tick();
        tick();
        check("t5 redo valid", 16'(out_valid), 16'd1);
        check("t5 redo z", 16'(out_z), 16'h46);
        check("t5 redo ops_done", ops_done, 16'd1);
        tick();
        tick();

        // Random consumer across pointer wrap
        sent = 0;
        got  = 0;
        cyc  = 0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        while (got < 9 && cyc < 400) begin
            in_valid  = (sent < 9);
            out_ready = 1'($urandom_range(0, 1));
            #0;
            push_fire = in_valid && in_ready;
            pop_fire  = out_valid && out_ready;
            obs       = {out_flags, out_z};
            tick();
            if (push_fire) begin
                s = {1'b0, in_a} + {1'b0, in_b};
                gq.push_back({7'b0, s[8], s[7:0]});
                sent++;
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            if (pop_fire) begin
                exp_r = (gq.size() > 0) ? gq.pop_front() : 16'hDEAD;
                check($sformatf("t6 result %0d", got), obs, exp_r);
                got++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        check("t6 results received", 16'(got), 16'd9);
        check("t6 ops_done", ops_done, 16'd10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
